// File: rtl/switch_out_sched_pkg.sv
// Shared constants and types for the switchcore egress schedulers.
package switch_pkg;

  localparam int unsigned N_PORTS    = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PORT_IDX_W = $clog2(N_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  // Round-robin successor of a port index, wrapping at N_PORTS.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(N_PORTS - 1)) ? '0 : p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/switch_out_sched_if.sv
// Input-FIFO head / egress lane bundle seen by one output scheduler.
interface switch_out_sched_if;
  import switch_pkg::*;

  logic [N_PORTS-1:0]            req;
  logic [N_PORTS*DATA_WIDTH-1:0] in_data;
  logic [N_PORTS-1:0]            in_eof;
  logic [N_PORTS-1:0]            rd_en;
  logic [N_PORTS-1:0]            grant;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_ctrl;

  // Scheduler side: pops the FIFOs and drives the egress lane.
  modport master (
    input  req, in_data, in_eof,
    output rd_en, grant, tx_data, tx_ctrl
  );

  // FIFO / lane side.
  modport slave (
    output req, in_data, in_eof,
    input  rd_en, grant, tx_data, tx_ctrl
  );

endinterface

// File: rtl/switch_out_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int unsigned N_PORTS = 4,
  localparam int unsigned IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_i;
  logic             found;

  // Walk upward from the pointer; the first set request wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    cand_i = '0;
    for (int unsigned s = 0; s < N_PORTS; s++) begin
      cand   = (32'(ptr) + s) % N_PORTS;
      cand_i = IDX_W'(cand);
      if (!found && req[cand_i]) begin
        found       = 1'b1;
        gnt[cand_i] = 1'b1;
        idx         = cand_i;
      end
    end
  end

endmodule

// File: rtl/switch_out_sched.sv
// Per-egress-port frame scheduler: round-robin over input FIFOs at frame
// granularity, IFG insertion, link_sync gating with frame drain.
// Optional counters frames_sent / frames_dropped with SWITCH_OUT_SCHED_STATS_EN.
module switch_out_sched
  import switch_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                link_sync,
  switch_out_sched_if.master  bus
`ifdef SWITCH_OUT_SCHED_STATS_EN
  ,
  output logic [15:0]         frames_sent,
  output logic [15:0]         frames_dropped
`endif
);

  localparam int unsigned GAP_W = 8;

  sched_state_t          state_q, state_d;
  port_idx_t             ptr_q, ptr_d;
  port_idx_t             own_q, own_d;
  logic [N_PORTS-1:0]    grant_q, grant_d;
  logic [N_PORTS-1:0]    rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_ctrl_q, tx_ctrl_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  logic [N_PORTS-1:0]    arb_gnt;
  port_idx_t             arb_idx;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_eof;

  rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Head byte of the current owner's FIFO.
  always_comb begin
    head_data = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (own_q == port_idx_t'(i)) head_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign head_eof = bus.in_eof[own_q];

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    grant_d   = grant_q;
    rd_en_d   = rd_en_q;
    tx_data_d = '0;
    tx_ctrl_d = 1'b0;
    gap_d     = gap_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        rd_en_d = '0;
        if (link_sync && (bus.req != '0)) begin
          grant_d = arb_gnt;
          rd_en_d = arb_gnt;
          own_d   = arb_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        if (link_sync) begin
          tx_data_d = head_data;
          tx_ctrl_d = 1'b1;
        end
        if (head_eof) begin
          // A frame whose eof is popped while the link is down is lost too.
          grant_d = '0;
          rd_en_d = '0;
          ptr_d   = next_port(own_q);
          gap_d   = '0;
          state_d = GAP;
        end else if (!link_sync) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Keep popping so the input FIFO ends frame-aligned.
        if (head_eof) begin
          grant_d = '0;
          rd_en_d = '0;
          ptr_d   = next_port(own_q);
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(IFG_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        rd_en_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      grant_q   <= '0;
      rd_en_q   <= '0;
      tx_data_q <= '0;
      tx_ctrl_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      grant_q   <= grant_d;
      rd_en_q   <= rd_en_d;
      tx_data_q <= tx_data_d;
      tx_ctrl_q <= tx_ctrl_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.grant   = grant_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_ctrl = tx_ctrl_q;

`ifdef SWITCH_OUT_SCHED_STATS_EN
  logic sent_inc_c;
  logic drop_inc_c;

  assign sent_inc_c = (state_q == XFER) && head_eof && link_sync;
  assign drop_inc_c = head_eof && ((state_q == DRAIN) || ((state_q == XFER) && !link_sync));

  // Sent count wraps; dropped count saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      if (sent_inc_c) frames_sent <= frames_sent + 16'd1;
      if (drop_inc_c && (frames_dropped != 16'hFFFF)) frames_dropped <= frames_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: doc/switch_out_sched.md
Name: switch_out_sched

Overview:
- Per-output-port scheduler for the 4-port switchcore; one instance drives each egress lane, i.e. one 8-bit slice of tx_data and one bit of tx_ctrl.
- Shares the egress lane between the input-side frame FIFOs that hold a frame destined to this port.
- Arbitration is round-robin at frame granularity: a grant is held until end-of-frame, then a mandatory inter-frame gap follows.
- The egress lane is gated by the port's link_sync bit.

Parameters:
- N_PORTS, 4, number of requesting inputs.
- DATA_WIDTH, 8, bits per egress lane.
- IFG_CYCLES, 12, idle cycles inserted after every frame; legal range 1..255.

Ports:
- clk  in  1  switch core clock.
- reset  in  1  asynchronous, active-low reset.
- link_sync  in  1  link-up for this egress port.
- req  in  N_PORTS  req[i] high: input i has at least one complete frame for this port at its FIFO head.
- in_data  in  N_PORTS*DATA_WIDTH  packed FWFT head bytes; input i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_eof  in  N_PORTS  in_eof[i] high: the head byte of input i is the last byte of its frame.
- rd_en  out  N_PORTS  one-hot pop strobe to the granted input FIFO.
- grant  out  N_PORTS  one-hot current owner; zero when no owner.
- tx_data  out  DATA_WIDTH  egress byte.
- tx_ctrl  out  1  high: tx_data carries a valid frame byte.

Behaviour:
- Reset values (reset low): rd_en=0, grant=0, tx_data=0, tx_ctrl=0, rr pointer=0, state=IDLE, gap counter=0.
- State machine: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - If link_sync=1 and req!=0, pick the first requester at or after the rr pointer, searching upward with wrap.
  - Set grant to the winner and go to XFER next cycle.
  - If link_sync=0, no grant is issued.
- XFER:
  - rd_en = grant every cycle.
  - The byte from in_data of the granted input is registered to tx_data with tx_ctrl=1, so tx lags the pop by 1 cycle.
  - When in_eof of the granted input is high on a popped byte:
    - that byte is the last transmitted;
    - the rr pointer becomes (winner+1) mod N_PORTS;
    - grant clears and the state goes to GAP.
  - Changes on req while in XFER are ignored.
- Link loss mid-frame:
  - If link_sync falls during XFER, go to DRAIN on the next cycle. tx_ctrl is forced 0 from that cycle onward.
  - DRAIN keeps popping (rd_en = grant) until eof, so the input FIFO stays frame-aligned; the frame counts as dropped.
  - DRAIN then goes to GAP.
  - link_sync returning high during DRAIN has no effect on the drained frame.
- GAP:
  - tx_ctrl=0, tx_data=0, rd_en=0 for exactly IFG_CYCLES cycles.
  - Then IDLE; arbitration happens in that IDLE cycle, so frame-to-frame spacing is IFG_CYCLES+1 idle tx cycles.
- Single-byte frame (eof on the first byte): one XFER cycle, then GAP.
- The previous owner re-requesting is lowest priority because of the pointer advance. A lone requester wins repeatedly.
- tx_data is 0 whenever tx_ctrl=0.
- Reset asserted mid-frame:
  - all outputs return to reset values asynchronously;
  - no recovery of the partial frame; the input side is reset by the same net.

Optional Feature:
- Macro SWITCH_OUT_SCHED_STATS_EN.
- With the macro defined, two extra outputs are present:
  - frames_sent (16 bits): increments on each fully transmitted eof and wraps.
  - frames_dropped (16 bits): increments on each DRAIN completion and saturates at 16'hFFFF.
  - Both counters reset to 0.
- Without the macro, neither port nor counter logic exists and behaviour is otherwise identical.

Decomposition:
- Package switch_pkg holds:
  - N_PORTS and DATA_WIDTH constants;
  - the sched_state_t enum {IDLE, XFER, DRAIN, GAP};
  - the port-index type logic [$clog2(N_PORTS)-1:0].
- One sub-module, rr_arbiter:
  - combinational, parameterised by N_PORTS;
  - inputs req and pointer; outputs one-hot gnt and the encoded index.
  - It is instantiated once; the FSM, gap counter, datapath mux and tx registers stay in switch_out_sched.

Test Plan:
- Link up, req=4'b0001, input 0 presents AA,BB,CC,DD with eof on DD:
  - tx_ctrl=1 for 4 cycles carrying AA..DD, starting 1 cycle after the first rd_en;
  - then 12 cycles of tx_ctrl=0.
- req=4'b1111 constantly, every frame 2 bytes: grant order 0,1,2,3,0; each frame separated by 13 idle tx cycles.
- Input 2 sends a 6-byte frame and link_sync drops after byte 3 is transmitted:
  - tx_ctrl=0 from the following cycle;
  - rd_en[2] continues until eof (6 pops total);
  - then GAP; with stats enabled, frames_dropped=1.
- link_sync=0 with req=4'b0110: grant and rd_en stay 0. Raising link_sync grants input 1 on the next arbitration.
- Single-byte frame with eof on input 3 (pointer=3), then req=4'b1001: the next grant goes to input 0.
- Assert reset mid-XFER: outputs are 0 immediately. After release with req=4'b0100, the pointer is 0 and input 2 is granted.
